// File: rtl/slice_add_sequencer_pkg.sv
// Shared constants, state encoding and byte-lane helpers for the slice add/sub sequencer.
package slice_add_sequencer_pkg;

    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_SLICES = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [SLICE_W-1:0] get_slice(input logic [DATA_W-1:0] word,
                                                     input logic [IDX_W-1:0]  idx);
        logic [SLICE_W-1:0] lane;
        unique case (idx)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

    function automatic logic [DATA_W-1:0] put_slice(input logic [DATA_W-1:0]  word,
                                                    input logic [IDX_W-1:0]   idx,
                                                    input logic [SLICE_W-1:0] lane);
        logic [DATA_W-1:0] merged;
        merged = word;
        unique case (idx)
            2'd0:    merged[7:0]   = lane;
            2'd1:    merged[15:8]  = lane;
            2'd2:    merged[23:16] = lane;
            default: merged[31:24] = lane;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/cl_sub_adder.sv
// 8-bit carry-lookahead slice: sum, group generate/propagate, and carry into the MSB.
module cl_sub_adder
    import slice_add_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] data_A,
    input  logic [SLICE_W-1:0] data_B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               G,
    output logic               P,
    output logic               overflow
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W-1:0] carry_in_vec;

    always_comb begin
        logic carry;
        logic grp_g;
        gen          = data_A & data_B;
        prop         = data_A ^ data_B;
        carry        = Cin;
        grp_g        = 1'b0;
        carry_in_vec = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            carry_in_vec[i] = carry;
            carry           = gen[i] | (prop[i] & carry);
            grp_g           = gen[i] | (prop[i] & grp_g);
        end
        S        = prop ^ carry_in_vec;
        G        = grp_g;
        P        = &prop;
        // Carry into bit 7, not the carry out; the sequencer derives signed overflow from it.
        overflow = carry_in_vec[SLICE_W-1];
    end

endmodule

// File: rtl/slice_add_sequencer.sv
// 32-bit add/subtract computed one byte per cycle through a single 8-bit CLA slice, LSB first.
module slice_add_sequencer
    import slice_add_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op_sub,
    input  logic [DATA_W-1:0] operand_A,
    input  logic [DATA_W-1:0] operand_B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              overflow
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic               carry_q, carry_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_g;
    logic               slice_p;
    logic               slice_c7;
    logic               slice_carry;

    assign slice_a = get_slice(a_q, idx_q);
    assign slice_b = get_slice(b_q, idx_q);

    cl_sub_adder u_slice (
        .data_A   (slice_a),
        .data_B   (slice_b),
        .Cin      (carry_q),
        .S        (slice_s),
        .G        (slice_g),
        .P        (slice_p),
        .overflow (slice_c7)
    );

    assign slice_carry = slice_g | (slice_p & carry_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = operand_A;
                    // Subtract as A + ~B + 1: the +1 enters as the first slice's carry-in.
                    b_d     = op_sub ? ~operand_B : operand_B;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d = put_slice(result_q, idx_q, slice_s);
                carry_d  = slice_carry;
                if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
                    cout_d  = slice_carry;
                    ovf_d   = slice_c7 ^ slice_carry;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/slice_add_sequencer.md
SLICE_ADD_SEQUENCER -- requirements
Module: slice_add_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock input 1, the sole clock, all state updates on its rising edge.
REQ-002 SHALL have port reset input 1, synchronous active-high reset.
REQ-003 SHALL have port start input 1, request to begin an operation.
REQ-004 SHALL have port op_sub input 1, 0 = A+B and 1 = A-B, sampled with start.
REQ-005 SHALL have port operand_A input 32, first operand, sampled with start.
REQ-006 SHALL have port operand_B input 32, second operand, sampled with start.
REQ-007 SHALL have port busy output 1, high while an operation is in progress.
REQ-008 SHALL have port done output 1, one-cycle pulse marking the result as valid.
REQ-009 SHALL have port result output 32, sum or difference.
REQ-010 SHALL have port carry_out output 1, carry out of bit 31 (for subtract, 1 = no borrow).
REQ-011 SHALL have port overflow output 1, two's-complement signed overflow.

Function
REQ-012 SHALL compute 32-bit add/subtract by time-multiplexing a single 8-bit CLA slice over four cycles, least-significant byte first.
REQ-013 SHALL have three states:
- IDLE
- RUN, with a 2-bit slice index 0..3
- DONE
REQ-014 IDLE or DONE with start=1 SHALL:
- latch operand_A into the A register
- latch (op_sub ? ~operand_B : operand_B) into the B register
- set the carry register to op_sub
- go to RUN with index 0
REQ-015 start in RUN SHALL be ignored, with no effect on state or registers.
REQ-016 In RUN, the slice SHALL receive byte [index] of the A and B registers, with Cin = the carry register.
REQ-017 In RUN, slice S SHALL be written to result byte [index].
REQ-018 In RUN, the carry register SHALL be loaded with slice_G | (slice_P & Cin); the slice's own overflow port is carry into bit 7 and SHALL NOT be used as the carry-out.
REQ-019 At index 3, SHALL:
- set carry_out to the computed carry
- set overflow to (slice overflow port XOR computed carry), i.e. carry-in to bit 31 XOR carry-out of bit 31
- go to DONE
REQ-020 At indices 0-2, the index SHALL increment and the state SHALL stay in RUN.
REQ-021 DONE with start=0 SHALL go to IDLE.
REQ-022 Latency: start sampled at edge T, done=1 during the cycle after edge T+4; this is a fixed 5-edge turnaround.
REQ-023 busy SHALL be 1 exactly in RUN.
REQ-024 done SHALL be 1 exactly in DONE.
REQ-025 result, carry_out and overflow SHALL hold their values from DONE until the next accepted start.
REQ-026 A start accepted in DONE (back-to-back) SHALL begin a new operation with no idle cycle between.
REQ-027 result bytes SHALL update progressively during RUN; they are valid only when done=1 or while in IDLE after a completed operation.
REQ-028 Operands SHALL be captured only at start; changing operand_A, operand_B or op_sub mid-operation SHALL have no effect.

Reset
REQ-029 reset=1 at a clock edge SHALL force state IDLE and index 0.
REQ-030 reset=1 SHALL clear to 0: result, carry_out, overflow, the A, B and carry registers, busy and done.
REQ-031 reset SHALL take priority over start in the same cycle.
REQ-032 reset mid-RUN SHALL abort the operation, produce no done pulse, and leave outputs at 0.

Structure
REQ-033 A shared package SHALL hold:
- state encoding constants IDLE/RUN/DONE
- constants SLICE_W=8, NUM_SLICES=4, DATA_W=32
REQ-034 SHALL instantiate exactly one existing cl_sub_adder (ports data_A, data_B, Cin, S, G, P, overflow) as its only sub-module; there SHALL be no other adder logic in the block.

Verification
REQ-035 SHALL cover: add 0xFFFFFFFF + 0x00000001 -> done after 5 edges, result 0x00000000, carry_out 1, overflow 0.
REQ-036 SHALL cover: add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry_out 0, overflow 1.
REQ-037 SHALL cover: sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry_out 0, overflow 0.
REQ-038 SHALL cover: sub 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, carry_out 1, overflow 1.
REQ-039 SHALL cover: start pulsed again during RUN with different operands -> ignored; first result 0x12345678 + 0x11111111 = 0x23456789.
REQ-040 SHALL cover: back-to-back start in DONE -> second done exactly 5 edges later.
REQ-041 SHALL cover: reset asserted at RUN index 2 -> IDLE next cycle, all outputs 0, no done pulse.
